// File: rtl/reg_file_pkg.sv
// Shared constants and types for the windowed register file.
// Physical layout: globals first, then per window an ins block and a locals block.
package reg_file_pkg;

  localparam int NUM_GLOBALS     = 8;
  localparam int REGS_PER_WINDOW = 16;
  localparam int VIS_REGS        = 32;
  localparam int BLOCK_REGS      = 8;

  typedef enum logic [1:0] {
    RGN_GLOBAL = 2'b00,
    RGN_OUT    = 2'b01,
    RGN_LOCAL  = 2'b10,
    RGN_IN     = 2'b11
  } region_e;

  function automatic int phys_count(input int nwin);
    return NUM_GLOBALS + REGS_PER_WINDOW * nwin;
  endfunction

endpackage

// File: rtl/reg_window_map.sv
// Visible register number to physical register index for a given window.
// The outs of a window are the ins of the window one below it, modulo NWINDOWS.
module reg_window_map
  import reg_file_pkg::*;
#(
  parameter int NWINDOWS = 4,
  parameter int CW       = 2,
  parameter int PW       = 7
) (
  input  logic [CW-1:0]                cwp_i,
  input  logic [$clog2(VIS_REGS)-1:0] vis_i,
  output logic [PW-1:0]                phys_o
);

  region_e       rgn;
  logic [CW-1:0] prev;
  int            win;
  int            off;
  int            idx;

  assign rgn = region_e'(vis_i[4:3]);

  always_comb begin
    prev = (cwp_i == '0) ? CW'(NWINDOWS - 1)
                         : cwp_i - CW'(1);
    win  = int'(cwp_i);
    off  = 0;
    idx  = 0;
    unique case (1'b1)
      (rgn == RGN_GLOBAL): idx = int'(vis_i[2:0]);
      (rgn == RGN_OUT): begin
        win = int'(prev);
        off = 0;
        idx = NUM_GLOBALS + win * REGS_PER_WINDOW
            + off + int'(vis_i[2:0]);
      end
      (rgn == RGN_LOCAL): begin
        off = BLOCK_REGS;
        idx = NUM_GLOBALS + win * REGS_PER_WINDOW
            + off + int'(vis_i[2:0]);
      end
      (rgn == RGN_IN): begin
        off = 0;
        idx = NUM_GLOBALS + win * REGS_PER_WINDOW
            + off + int'(vis_i[2:0]);
      end
      default: idx = 0;
    endcase
    phys_o = PW'(idx);
  end

endmodule

// File: rtl/windowed_reg_file.sv
// SPARC-style windowed register file with save/restore window shifting,
// window invalid mask traps and same-cycle write bypass.
module windowed_reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [4:0]                  rd,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        save,
  input  logic                        restore,
  input  logic                        wim_we,
  input  logic [NWINDOWS-1:0]         wim_in,
  output logic [WIDTH-1:0]            rd_a,
  output logic [WIDTH-1:0]            rd_b,
  output logic [$clog2(NWINDOWS)-1:0] cwp,
  output logic                        trap_overflow,
  output logic                        trap_underflow
);

  localparam int CW    = $clog2(NWINDOWS);
  localparam int NPHYS = phys_count(NWINDOWS);
  localparam int PW    = $clog2(NPHYS);

  logic [WIDTH-1:0]    regs_q [NPHYS];
  logic [CW-1:0]       cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [CW-1:0]       dn, up;
  logic [PW-1:0]       pa, pb, pd;
  logic                wr_act;

  reg_window_map #(
    .NWINDOWS(NWINDOWS), .CW(CW), .PW(PW)
  ) u_map_a (
    .cwp_i(cwp_q), .vis_i(rs1), .phys_o(pa)
  );

  reg_window_map #(
    .NWINDOWS(NWINDOWS), .CW(CW), .PW(PW)
  ) u_map_b (
    .cwp_i(cwp_q), .vis_i(rs2), .phys_o(pb)
  );

  reg_window_map #(
    .NWINDOWS(NWINDOWS), .CW(CW), .PW(PW)
  ) u_map_d (
    .cwp_i(cwp_q), .vis_i(rd), .phys_o(pd)
  );

  // A write abandoned by Clr must not leak through the bypass either.
  assign wr_act = wr_en && (rd != '0) && !Clr;

  always_comb begin
    rd_a = regs_q[pa];
    if (rs1 == '0)
      rd_a = '0;
    else if (wr_act && (pd == pa))
      rd_a = wr_data;
  end

  always_comb begin
    rd_b = regs_q[pb];
    if (rs2 == '0)
      rd_b = '0;
    else if (wr_act && (pd == pb))
      rd_b = wr_data;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < NPHYS; i++)
        regs_q[i] <= '0;
    end else if (wr_en && (rd != '0)) begin
      regs_q[pd] <= wr_data;
    end
  end

  always_comb begin
    dn    = (cwp_q == '0) ? CW'(NWINDOWS - 1)
                          : cwp_q - CW'(1);
    up    = (cwp_q == CW'(NWINDOWS - 1)) ? '0
                                         : cwp_q + CW'(1);
    cwp_d = cwp_q;
    wim_d = wim_we ? wim_in : wim_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    // Shifts test the mask as it was before any load this cycle.
    if (save && !restore) begin
      if (wim_q[dn]) ovf_d = 1'b1;
      else           cwp_d = dn;
    end else if (restore && !save) begin
      if (wim_q[up]) unf_d = 1'b1;
      else           cwp_d = up;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      cwp_q <= '0;
      wim_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      wim_q <= wim_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cwp            = cwp_q;
  assign trap_overflow  = ovf_q;
  assign trap_underflow = unf_q;

endmodule

// File: tb/tb_windowed_reg_file.sv
// Self-checking bench for windowed_reg_file against a window-rule model.
// Directed scenarios followed by randomized traffic.
module tb_windowed_reg_file;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int NP = 8 + 16 * N;

  logic          Clk = 1'b0;
  logic          Clr;
  logic [4:0]    rs1, rs2, rd;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          save, restore;
  logic          wim_we;
  logic [N-1:0]  wim_in;
  logic [W-1:0]  rd_a, rd_b;
  logic [1:0]    cwp;
  logic          trap_overflow, trap_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_regs [NP];
  int           m_cwp;
  logic [N-1:0] m_wim;
  logic         m_ovf, m_unf;

  windowed_reg_file #(.WIDTH(W), .NWINDOWS(N)) dut (
    .Clk(Clk), .Clr(Clr),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .wr_en(wr_en), .wr_data(wr_data),
    .save(save), .restore(restore),
    .wim_we(wim_we), .wim_in(wim_in),
    .rd_a(rd_a), .rd_b(rd_b), .cwp(cwp),
    .trap_overflow(trap_overflow),
    .trap_underflow(trap_underflow)
  );

  always #5 Clk = ~Clk;

  function automatic int phys(int c, int r);
    if (r < 8)  return r;
    if (r < 16) return 8 + ((c + N - 1) % N) * 16 + (r - 8);
    if (r < 24) return 8 + c * 16 + 8 + (r - 16);
    return 8 + c * 16 + (r - 24);
  endfunction

  function automatic logic [W-1:0] m_read(int r);
    if (r == 0) return '0;
    if (wr_en && rd != 0 && phys(m_cwp, int'(rd)) == phys(m_cwp, r))
      return wr_data;
    return m_regs[phys(m_cwp, r)];
  endfunction

  task automatic idle();
    wr_en = 0; rd = 0; wr_data = '0;
    save = 0; restore = 0;
    wim_we = 0; wim_in = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_regs[i] = '0;
    m_cwp = 0; m_wim = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic clk_step();
    int  nc, n;
    logic ov, un;
    @(posedge Clk);
    nc = m_cwp; ov = 0; un = 0;
    if (wr_en && rd != 0)
      m_regs[phys(m_cwp, int'(rd))] = wr_data;
    if (save && !restore) begin
      n = (m_cwp + N - 1) % N;
      if (m_wim[n]) ov = 1; else nc = n;
    end else if (restore && !save) begin
      n = (m_cwp + 1) % N;
      if (m_wim[n]) un = 1; else nc = n;
    end
    if (wim_we) m_wim = wim_in;
    m_cwp = nc; m_ovf = ov; m_unf = un;
    #1;
    idle();
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    idle();
    rs1 = 0; rs2 = 0;
    Clr = 1;
    @(negedge Clk);
    Clr = 0;
    model_reset();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    if (cwp !== 2'd0 || trap_overflow !== 1'b0
        || trap_underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state cwp=%0d ovf=%b unf=%b need 0/0/0",
               cwp, trap_overflow, trap_underflow);
    end
    n_cmp++;
    for (int w = 0; w < N; w++) begin
      if (int'(cwp) !== m_cwp) begin
        n_bad++;
        $display("FAIL reset_cwp got %0d need %0d", cwp, m_cwp);
      end
      n_cmp++;
      for (int r = 0; r < 32; r++) begin
        rs1 = 5'(r); rs2 = 5'((r + 7) % 32);
        #1;
        if (rd_a !== '0 || rd_b !== '0) begin
          n_bad++;
          $display("FAIL reset_regs w=%0d r=%0d a=%h b=%h need 0",
                   m_cwp, r, rd_a, rd_b);
        end
        n_cmp++;
      end
      save = 1;
      clk_step();
    end
  endtask

  task automatic test_window_alias();
    apply_reset();
    wr_en = 1; rd = 5'd8; wr_data = 32'h0000_1234;
    clk_step();
    save = 1;
    clk_step();
    rs1 = 5'd24; #1;
    if (cwp !== 2'd3 || rd_a !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL alias_save cwp=%0d r24=%h need 3/00001234",
               cwp, rd_a);
    end
    n_cmp++;
    restore = 1;
    clk_step();
    rs1 = 5'd8; #1;
    if (cwp !== 2'd0 || rd_a !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL alias_restore cwp=%0d r8=%h need 0/00001234",
               cwp, rd_a);
    end
    n_cmp++;
  endtask

  task automatic test_globals();
    apply_reset();
    wr_en = 1; rd = 5'd1; wr_data = 32'hDEAD_BEEF;
    clk_step();
    for (int k = 0; k < 2; k++) begin
      save = 1;
      clk_step();
      rs1 = 5'd1; #1;
      if (int'(cwp) !== 3 - k || rd_a !== 32'hDEAD_BEEF) begin
        n_bad++;
        $display("FAIL global_r1 cwp=%0d r1=%h need %0d/deadbeef",
                 cwp, rd_a, 3 - k);
      end
      n_cmp++;
    end
    wr_en = 1; rd = 5'd0; wr_data = 32'd5;
    rs2 = 5'd0; #1;
    if (rd_b !== '0) begin
      n_bad++;
      $display("FAIL r0_bypass got %h need 0", rd_b);
    end
    n_cmp++;
    clk_step();
    rs1 = 5'd0; #1;
    if (rd_a !== '0) begin
      n_bad++;
      $display("FAIL r0_write got %h need 0", rd_a);
    end
    n_cmp++;
  endtask

  task automatic test_traps();
    apply_reset();
    wim_we = 1; wim_in = 4'b1000;
    clk_step();
    save = 1;
    clk_step();
    if (trap_overflow !== 1'b1 || trap_underflow !== 1'b0
        || cwp !== 2'd0) begin
      n_bad++;
      $display("FAIL ovf_trap ovf=%b unf=%b cwp=%0d need 1/0/0",
               trap_overflow, trap_underflow, cwp);
    end
    n_cmp++;
    clk_step();
    if (trap_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_pulse got %b need 0", trap_overflow);
    end
    n_cmp++;
    wim_we = 1; wim_in = 4'b0010;
    clk_step();
    restore = 1;
    clk_step();
    if (trap_underflow !== 1'b1 || trap_overflow !== 1'b0
        || cwp !== 2'd0) begin
      n_bad++;
      $display("FAIL unf_trap unf=%b ovf=%b cwp=%0d need 1/0/0",
               trap_underflow, trap_overflow, cwp);
    end
    n_cmp++;
    clk_step();
    if (trap_underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL unf_pulse got %b need 0", trap_underflow);
    end
    n_cmp++;
    // Old mask still guards a save issued with a new load.
    wim_we = 1; wim_in = 4'b0000; save = 1;
    rs1 = 5'd0;
    clk_step();
    if (int'(cwp) !== m_cwp || trap_overflow !== m_ovf) begin
      n_bad++;
      $display("FAIL wim_old cwp=%0d ovf=%b need %0d/%b",
               cwp, trap_overflow, m_cwp, m_ovf);
    end
    n_cmp++;
  endtask

  task automatic test_bypass();
    apply_reset();
    wr_en = 1; rd = 5'd17; wr_data = 32'hA5A5_A5A5;
    rs1 = 5'd17; rs2 = 5'd17; #1;
    if (rd_a !== 32'hA5A5_A5A5 || rd_b !== 32'hA5A5_A5A5) begin
      n_bad++;
      $display("FAIL bypass a=%h b=%h need a5a5a5a5", rd_a, rd_b);
    end
    n_cmp++;
    clk_step();
    save = 1; restore = 1;
    clk_step();
    if (cwp !== 2'd0 || trap_overflow !== 1'b0
        || trap_underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL save_restore cwp=%0d ovf=%b unf=%b need 0/0/0",
               cwp, trap_overflow, trap_underflow);
    end
    n_cmp++;
  endtask

  task automatic test_clr_mid();
    apply_reset();
    save = 1;
    clk_step();
    wr_en = 1; rd = 5'd17; wr_data = 32'h1111_2222;
    clk_step();
    wr_en = 1; rd = 5'd17; wr_data = 32'h3333_4444;
    save = 1; rs1 = 5'd17;
    @(negedge Clk);
    #2;
    Clr = 1;
    #1;
    if (cwp !== 2'd0 || rd_a !== '0) begin
      n_bad++;
      $display("FAIL clr_async cwp=%0d r17=%h need 0/0", cwp, rd_a);
    end
    n_cmp++;
    @(posedge Clk);
    #1;
    idle();
    @(negedge Clk);
    Clr = 0;
    model_reset();
    @(posedge Clk);
    #1;
    rs1 = 5'd17; #1;
    if (cwp !== 2'd0 || rd_a !== '0) begin
      n_bad++;
      $display("FAIL clr_after cwp=%0d r17=%h need 0/0", cwp, rd_a);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    int op;
    logic [W-1:0] ea, eb;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      rd      = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd
                                        : 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      op = $urandom_range(0, 7);
      save    = (op == 0 || op == 2);
      restore = (op == 1 || op == 2);
      wim_we  = ($urandom_range(0, 9) == 0);
      wim_in  = ($urandom_range(0, 1) == 0) ? 4'b0000
              : 4'(1 << $urandom_range(0, 3));
      #1;
      ea = m_read(int'(rs1));
      eb = m_read(int'(rs2));
      if (rd_a !== ea || rd_b !== eb || int'(cwp) !== m_cwp) begin
        n_bad++;
        $display("FAIL rand_read i=%0d a=%h b=%h cwp=%0d need %h/%h/%0d",
                 i, rd_a, rd_b, cwp, ea, eb, m_cwp);
      end
      n_cmp++;
      clk_step();
      if (trap_overflow !== m_ovf || trap_underflow !== m_unf) begin
        n_bad++;
        $display("FAIL rand_trap i=%0d ovf=%b unf=%b need %b/%b",
                 i, trap_overflow, trap_underflow, m_ovf, m_unf);
      end
      n_cmp++;
    end
  endtask

  initial begin
    Clr = 1;
    rs1 = 0; rs2 = 0;
    idle();
    model_reset();
    test_reset();
    test_window_alias();
    test_globals();
    test_traps();
    test_bypass();
    test_clr_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/windowed_reg_file.md
WINDOWED_REG_FILE -- requirements
Module: windowed_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register.
REQ-002 SHALL have parameter NWINDOWS, default 4, number of register windows, legal range 2..32.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port Clr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rs1, rs2  input  5 each  visible register numbers for read ports A and B.
REQ-006 SHALL have ports rd  input  5, wr_en  input  1, wr_data  input  WIDTH  for the write port.
REQ-007 SHALL have ports save, restore  input  1 each  window-shift requests.
REQ-008 SHALL have ports wim_we  input  1, wim_in  input  NWINDOWS  for loading the window invalid mask.
REQ-009 SHALL have ports rd_a, rd_b  output  WIDTH each  read data for rs1 and rs2.
REQ-010 SHALL have port cwp  output  clog2(NWINDOWS)  current window pointer.
REQ-011 SHALL have ports trap_overflow, trap_underflow  output  1 each  registered one-cycle trap pulses.

Function
REQ-012 SHALL hold 8 + 16*NWINDOWS physical registers: 8 globals, then per window w an 8-register ins block and an 8-register locals block.
REQ-013 SHALL map visible r0-r7 to the globals, r16-r23 to the locals of cwp, r24-r31 to the ins of cwp, and r8-r15 to the ins of window (cwp-1) mod NWINDOWS.
REQ-014 SHALL return 0 on any read of r0 and SHALL discard writes to r0.
REQ-015 SHALL produce rd_a/rd_b combinationally (zero latency) from rs1/rs2 and the current cwp.
REQ-016 SHALL write wr_data to the mapped physical register of rd on a rising Clk edge when wr_en=1, using the pre-edge cwp.
REQ-017 SHALL bypass: when wr_en=1 and rd maps to the same physical register as rs1 (or rs2), with rd != 0, rd_a (or rd_b) SHALL show wr_data in that cycle.
REQ-018 SHALL on save=1, restore=0 compute n=(cwp-1) mod NWINDOWS; if wim[n]=0, cwp<=n; otherwise cwp unchanged and trap_overflow=1 for the next cycle.
REQ-019 SHALL on restore=1, save=0 compute n=(cwp+1) mod NWINDOWS; if wim[n]=0, cwp<=n; otherwise cwp unchanged and trap_underflow=1 for the next cycle.
REQ-020 SHALL treat save=1 and restore=1 together as a no-op: cwp unchanged, no trap.
REQ-021 SHALL wrap cwp modulo NWINDOWS in both directions, including non-power-of-two NWINDOWS.
REQ-022 SHALL load wim<=wim_in on a rising edge with wim_we=1; a save/restore in the same cycle SHALL test the old wim.
REQ-023 SHALL deassert each trap output after one cycle unless a new trapping request occurs.

Reset
REQ-024 SHALL on Clr=1, regardless of Clk, set all physical registers to 0, cwp=0, wim=0, trap_overflow=0, trap_underflow=0.
REQ-025 SHALL abandon any write, save, restore or wim load pending in a cycle where Clr is asserted; Clr has priority over all inputs.
REQ-026 SHALL resume normal operation on the first rising Clk edge after Clr deasserts.

Structure
REQ-027 SHALL place the constants NUM_GLOBALS=8, REGS_PER_WINDOW=16 and VIS_REGS=32 in the shared package reg_file_pkg.
REQ-028 SHALL implement the visible-to-physical mapping in one combinational sub-module, reg_window_map, instantiated three times (rs1, rs2, rd).

Verification (WIDTH=32, NWINDOWS=4)
REQ-029 SHALL check: after reset, read r0-r31 in every window -> all 0; cwp=0.
REQ-030 SHALL check: cwp=0, write r8=0x00001234, save -> cwp=3, r24 reads 0x00001234; restore -> cwp=0, r8 reads 0x00001234.
REQ-031 SHALL check: write r1=0xDEADBEEF, save twice -> r1 reads 0xDEADBEEF in windows 3 and 2; write r0=5 -> r0 reads 0.
REQ-032 SHALL check: wim=4'b1000, cwp=0, save -> trap_overflow=1 for one cycle, cwp stays 0; wim=4'b0010, restore -> trap_underflow=1, cwp stays 0.
REQ-033 SHALL check: wr_en=1, rd=rs1=r17, wr_data=0xA5A5A5A5 -> rd_a=0xA5A5A5A5 in the same cycle; save and restore together -> cwp unchanged, no trap.
REQ-034 SHALL check: Clr asserted mid-cycle during a save with a register write -> cwp=0 and the written register reads 0 immediately, without a clock edge.
